// File: rtl/stream_mux.sv
// -----------------------------------------------------------------------------
// stream_mux
// N_CH-input valid/ready stream multiplexer with a registered output stage.
// Two arbitration modes:
//   mode = 0 : fixed select, channel s is granted when it is valid.
//   mode = 1 : round-robin, search starts at ptr and wraps modulo N_CH.
// The output register accepts a new word whenever it is empty or being
// drained (load = !y_valid || y_ready), which gives one word per cycle.
//
// Ports
//   clk      : rising-edge clock
//   rst      : asynchronous active-high reset
//   mode     : 0 = fixed select, 1 = round-robin
//   s        : channel select used in fixed mode
//   i_data   : N_CH*DW packed input data, channel k at [k*DW +: DW]
//   i_valid  : per-channel valid
//   i_ready  : per-channel ready (combinational, one-hot or zero)
//   y_data   : registered output data
//   y_valid  : registered output valid
//   y_ready  : downstream ready
//   y_ch     : registered source channel of y_data
// -----------------------------------------------------------------------------
module stream_mux #(
   parameter int N_CH = 8,
   parameter int DW   = 8,
   parameter int SW   = 3
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic                 mode,
   input  logic [SW-1:0]        s,
   input  logic [N_CH*DW-1:0]   i_data,
   input  logic [N_CH-1:0]      i_valid,
   output logic [N_CH-1:0]      i_ready,
   output logic [DW-1:0]        y_data,
   output logic                 y_valid,
   input  logic                 y_ready,
   output logic [SW-1:0]        y_ch
);

   logic [SW-1:0]   ptr;
   logic            load_p0;
   logic            gnt_vld_p0;
   logic [SW-1:0]   gnt_p0;
   logic [DW-1:0]   sel_data_p0;
   logic [N_CH-1:0] rot_p0;
   int              sum_p0;

   // ---- stage p0: arbitration (combinational) ----
   always_comb begin
      load_p0    = !y_valid || y_ready;
      gnt_vld_p0 = 1'b0;
      gnt_p0     = '0;
      sum_p0     = 0;
      // Rotate valids so that bit 0 is the channel at ptr; the lowest set
      // bit of the rotated vector is then the first hit in search order.
      rot_p0     = N_CH'({i_valid, i_valid} >> ptr);
      if (mode) begin
         for (int j = N_CH - 1; j >= 0; j--) begin
            if (rot_p0[j]) begin
               gnt_vld_p0 = 1'b1;
               sum_p0     = int'(ptr) + j;
            end
         end
         if (sum_p0 >= N_CH) sum_p0 = sum_p0 - N_CH;
         gnt_p0 = SW'(sum_p0);
      end else begin
         // Out-of-range s never matches any k, so it yields no grant.
         for (int k = 0; k < N_CH; k++) begin
            if (int'(s) == k && i_valid[k]) begin
               gnt_vld_p0 = 1'b1;
               gnt_p0     = s;
            end
         end
      end
   end

   always_comb begin
      sel_data_p0 = '0;
      for (int k = 0; k < N_CH; k++) begin
         if (int'(gnt_p0) == k) sel_data_p0 = i_data[k*DW +: DW];
      end
   end

   // Ready is gated by rst so nothing appears accepted while in reset.
   always_comb begin
      i_ready = '0;
      for (int k = 0; k < N_CH; k++) begin
         i_ready[k] = load_p0 && gnt_vld_p0 && !rst && (int'(gnt_p0) == k);
      end
   end

   // ---- stage p1: output register and round-robin pointer ----
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         y_valid <= 1'b0;
         y_data  <= '0;
         y_ch    <= '0;
         ptr     <= '0;
      end else if (load_p0) begin
         if (gnt_vld_p0) begin
            y_valid <= 1'b1;
            y_data  <= sel_data_p0;
            y_ch    <= gnt_p0;
            if (mode) begin
               ptr <= (int'(gnt_p0) == N_CH - 1) ? '0 : gnt_p0 + SW'(1);
            end
         end else begin
            y_valid <= 1'b0;
         end
      end
   end

endmodule

// File: tb/tb_stream_mux.sv
module tb_stream_mux;

   localparam int N_CH = 8;
   localparam int DW   = 8;
   localparam int SW   = 3;

   logic                clk;
   logic                rst;
   logic                mode;
   logic [SW-1:0]       s;
   logic [N_CH*DW-1:0]  i_data;
   logic [N_CH-1:0]     i_valid;
   logic [N_CH-1:0]     i_ready;
   logic [DW-1:0]       y_data;
   logic                y_valid;
   logic                y_ready;
   logic [SW-1:0]       y_ch;

   int n_cmp = 0;
   int n_bad = 0;

   stream_mux #(.N_CH(N_CH), .DW(DW), .SW(SW)) dut (
      .clk     (clk),
      .rst     (rst),
      .mode    (mode),
      .s       (s),
      .i_data  (i_data),
      .i_valid (i_valid),
      .i_ready (i_ready),
      .y_data  (y_data),
      .y_valid (y_valid),
      .y_ready (y_ready),
      .y_ch    (y_ch)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic set_default_data();
      for (int k = 0; k < N_CH; k++) i_data[k*DW +: DW] = 8'h10 + 8'(k);
   endtask

   task automatic test_reset();
      rst = 1'b1; mode = 1'b0; s = 3'd0; i_valid = 8'hFF; y_ready = 1'b1;
      set_default_data();
      step(); step();
      n_cmp++; if (y_valid !== 1'b0) begin n_bad++; $display("FAIL reset_y_valid got=%b want=0", y_valid); end
      n_cmp++; if (y_data !== 8'h00) begin n_bad++; $display("FAIL reset_y_data got=%h want=00", y_data); end
      n_cmp++; if (y_ch !== 3'd0) begin n_bad++; $display("FAIL reset_y_ch got=%0d want=0", y_ch); end
      n_cmp++; if (i_ready !== 8'h00) begin n_bad++; $display("FAIL reset_i_ready got=%h want=00", i_ready); end
      rst = 1'b0;
   endtask

   task automatic test_fixed();
      mode = 1'b0; s = 3'd5; i_valid = 8'hFF; y_ready = 1'b1;
      #1;
      n_cmp++; if (i_ready !== 8'h20) begin n_bad++; $display("FAIL fixed_first_ready got=%h want=20", i_ready); end
      for (int c = 0; c < 4; c++) begin
         step();
         n_cmp++; if (y_valid !== 1'b1) begin n_bad++; $display("FAIL fixed_y_valid cyc=%0d got=%b want=1", c, y_valid); end
         n_cmp++; if (y_data !== 8'h15) begin n_bad++; $display("FAIL fixed_y_data cyc=%0d got=%h want=15", c, y_data); end
         n_cmp++; if (y_ch !== 3'd5) begin n_bad++; $display("FAIL fixed_y_ch cyc=%0d got=%0d want=5", c, y_ch); end
         n_cmp++; if (i_ready !== 8'h20) begin n_bad++; $display("FAIL fixed_i_ready cyc=%0d got=%h want=20", c, i_ready); end
      end
   endtask

   task automatic test_no_grant();
      s = 3'd3; i_valid = 8'hF7;
      #1;
      n_cmp++; if (i_ready !== 8'h00) begin n_bad++; $display("FAIL nogrant_i_ready got=%h want=00", i_ready); end
      step();
      n_cmp++; if (y_valid !== 1'b0) begin n_bad++; $display("FAIL nogrant_y_valid got=%b want=0", y_valid); end
      n_cmp++; if (y_data !== 8'h15) begin n_bad++; $display("FAIL nogrant_hold_data got=%h want=15", y_data); end
      n_cmp++; if (y_ch !== 3'd5) begin n_bad++; $display("FAIL nogrant_hold_ch got=%0d want=5", y_ch); end
      step();
      n_cmp++; if (y_valid !== 1'b0) begin n_bad++; $display("FAIL nogrant_y_valid2 got=%b want=0", y_valid); end
   endtask

   task automatic test_round_robin();
      logic [2:0] exp_seq [6];
      logic [7:0] exp_rdy;
      exp_seq = '{3'd0, 3'd4, 3'd7, 3'd0, 3'd4, 3'd7};
      mode = 1'b1; i_valid = 8'h91; y_ready = 1'b1;
      for (int c = 0; c < 6; c++) begin
         #1;
         exp_rdy = 8'h01 << exp_seq[c];
         n_cmp++; if (i_ready !== exp_rdy) begin n_bad++; $display("FAIL rr_i_ready idx=%0d got=%h want=%h", c, i_ready, exp_rdy); end
         step();
         n_cmp++; if (y_ch !== exp_seq[c]) begin n_bad++; $display("FAIL rr_y_ch idx=%0d got=%0d want=%0d", c, y_ch, exp_seq[c]); end
         n_cmp++; if (y_data !== 8'h10 + 8'(exp_seq[c])) begin n_bad++; $display("FAIL rr_y_data idx=%0d got=%h want=%h", c, y_data, 8'h10 + 8'(exp_seq[c])); end
         n_cmp++; if (y_valid !== 1'b1) begin n_bad++; $display("FAIL rr_y_valid idx=%0d got=%b want=1", c, y_valid); end
      end
   endtask

   task automatic test_stall();
      mode = 1'b0; s = 3'd2; i_valid = 8'h04; i_data[2*DW +: DW] = 8'hAB; y_ready = 1'b1;
      step();
      n_cmp++; if (y_data !== 8'hAB) begin n_bad++; $display("FAIL stall_load_data got=%h want=ab", y_data); end
      n_cmp++; if (y_ch !== 3'd2) begin n_bad++; $display("FAIL stall_load_ch got=%0d want=2", y_ch); end
      y_ready = 1'b0; i_data[2*DW +: DW] = 8'hCD;
      for (int c = 0; c < 3; c++) begin
         #1;
         n_cmp++; if (i_ready !== 8'h00) begin n_bad++; $display("FAIL stall_i_ready cyc=%0d got=%h want=00", c, i_ready); end
         step();
         n_cmp++; if (y_data !== 8'hAB) begin n_bad++; $display("FAIL stall_hold_data cyc=%0d got=%h want=ab", c, y_data); end
         n_cmp++; if (y_valid !== 1'b1) begin n_bad++; $display("FAIL stall_hold_valid cyc=%0d got=%b want=1", c, y_valid); end
      end
      y_ready = 1'b1;
      #1;
      n_cmp++; if (i_ready !== 8'h04) begin n_bad++; $display("FAIL stall_resume_ready got=%h want=04", i_ready); end
      step();
      n_cmp++; if (y_data !== 8'hCD) begin n_bad++; $display("FAIL stall_resume_data got=%h want=cd", y_data); end
      set_default_data();
   endtask

   task automatic test_mode_switch();
      // ptr is 0 here: round-robin wrapped to 0 and fixed accepts held it.
      mode = 1'b1; i_valid = 8'h06; y_ready = 1'b1;
      step();
      n_cmp++; if (y_ch !== 3'd1) begin n_bad++; $display("FAIL msw_rr_ch got=%0d want=1", y_ch); end
      y_ready = 1'b0; mode = 1'b0; s = 3'd6; i_valid = 8'h46;
      #1;
      n_cmp++; if (i_ready !== 8'h00) begin n_bad++; $display("FAIL msw_held_ready got=%h want=00", i_ready); end
      step();
      n_cmp++; if (y_ch !== 3'd1 || y_data !== 8'h11) begin n_bad++; $display("FAIL msw_held_word got=%0d/%h want=1/11", y_ch, y_data); end
      y_ready = 1'b1;
      #1;
      n_cmp++; if (i_ready !== 8'h40) begin n_bad++; $display("FAIL msw_fixed_ready got=%h want=40", i_ready); end
      step();
      n_cmp++; if (y_ch !== 3'd6 || y_data !== 8'h16) begin n_bad++; $display("FAIL msw_fixed_word got=%0d/%h want=6/16", y_ch, y_data); end
      // ptr should still be 2 after the fixed accept, so ch2 beats ch0/ch1.
      mode = 1'b1; i_valid = 8'h07;
      step();
      n_cmp++; if (y_ch !== 3'd2) begin n_bad++; $display("FAIL msw_ptr_hold got=%0d want=2", y_ch); end
   endtask

   task automatic test_async_reset();
      // ptr is 3 and a word is held when reset hits between edges.
      y_ready = 1'b0; i_valid = 8'h0A;
      step();
      n_cmp++; if (y_valid !== 1'b1) begin n_bad++; $display("FAIL areset_pre_valid got=%b want=1", y_valid); end
      #2 rst = 1'b1;
      #1;
      n_cmp++; if (y_valid !== 1'b0) begin n_bad++; $display("FAIL areset_y_valid got=%b want=0", y_valid); end
      n_cmp++; if (y_data !== 8'h00 || y_ch !== 3'd0) begin n_bad++; $display("FAIL areset_word got=%h/%0d want=00/0", y_data, y_ch); end
      n_cmp++; if (i_ready !== 8'h00) begin n_bad++; $display("FAIL areset_i_ready got=%h want=00", i_ready); end
      step();
      rst = 1'b0; y_ready = 1'b1; mode = 1'b1;
      #1;
      n_cmp++; if (i_ready !== 8'h02) begin n_bad++; $display("FAIL areset_first_ready got=%h want=02", i_ready); end
      step();
      n_cmp++; if (y_ch !== 3'd1 || y_valid !== 1'b1) begin n_bad++; $display("FAIL areset_first_grant got=%0d/%b want=1/1", y_ch, y_valid); end
   endtask

   initial begin
      test_reset();
      test_fixed();
      test_no_grant();
      test_round_robin();
      test_stall();
      test_mode_switch();
      test_async_reset();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
